// File: rtl/ntt_stage2_ctrl.sv
// Two-layer NTT sequencer: walks the schedule ROM twice (lo then hi descriptors), in-place CT butterflies mod Q.
// Latency 5 cycles rom_addr->write, one butterfly per cycle; no backpressure, the RAM must accept every write.
module ntt_stage2_ctrl #(
    parameter int Q   = 3329,
    parameter int LAT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [6:0]  rom_addr,
    input  logic [63:0] rom_dout,
    output logic [7:0]  rd_addr_a,
    output logic [7:0]  rd_addr_b,
    input  logic [11:0] rd_data_a,
    input  logic [11:0] rd_data_b,
    output logic        wr_en,
    output logic [7:0]  wr_addr_a,
    output logic [7:0]  wr_addr_b,
    output logic [11:0] wr_data_a,
    output logic [11:0] wr_data_b
);
    localparam int M = (1 << 24) / Q;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state_q;
    logic        pass_q, busy_q, done_q;
    logic [6:0]  rom_addr_q;
    logic [2:0]  drain_q;

    logic        iss_q, hi_q;
    logic        v1_q, v2_q, v3_q, wr_en_q;
    logic [11:0] z1_q, a2_q, a3_q, quo_q;
    logic [7:0]  ia1_q, ib1_q, ia2_q, ib2_q, ia3_q, ib3_q;
    logic [23:0] prod_q, prod3_q;
    logic [7:0]  wr_addr_a_q, wr_addr_b_q;
    logic [11:0] wr_data_a_q, wr_data_b_q;

    logic [11:0] zeta;
    logic [7:0]  idx_a, idx_b;
    logic [23:0] r_full;
    logic [11:0] t, a_new, b_new;
    logic [12:0] sum;
    wire         unused_bits = ^{rom_dout[63:60], rom_dout[31:28]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pass_q     <= 1'b0;
            rom_addr_q <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= ISSUE;
                        pass_q     <= 1'b0;
                        rom_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (rom_addr_q == 7'd127) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end else begin
                        rom_addr_q <= rom_addr_q + 7'd1;
                    end
                end
                DRAIN: begin
                    // Exit on the cycle the pass's last write is on the port.
                    if (drain_q == 3'(LAT - 1)) begin
                        if (!pass_q) begin
                            state_q    <= ISSUE;
                            pass_q     <= 1'b1;
                            rom_addr_q <= '0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    rom_addr_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        zeta  = hi_q ? rom_dout[59:48] : rom_dout[27:16];
        idx_a = hi_q ? rom_dout[47:40] : rom_dout[15:8];
        idx_b = hi_q ? rom_dout[39:32] : rom_dout[7:0];
    end

    // Barrett quotient from floor(2^24/Q) undershoots by at most one, so one conditional subtract suffices.
    always_comb begin
        r_full = prod3_q - 24'(quo_q) * 24'(Q);
        t      = (r_full >= 24'(Q)) ? 12'(r_full - 24'(Q)) : 12'(r_full);
        sum    = {1'b0, a3_q} + {1'b0, t};
        a_new  = (sum >= 13'(Q)) ? 12'(sum - 13'(Q)) : 12'(sum);
        b_new  = (a3_q >= t) ? (a3_q - t) : 12'({1'b0, a3_q} + 13'(Q) - {1'b0, t});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q       <= 1'b0;
            hi_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            z1_q        <= '0;
            ia1_q       <= '0;
            ib1_q       <= '0;
            prod_q      <= '0;
            a2_q        <= '0;
            ia2_q       <= '0;
            ib2_q       <= '0;
            quo_q       <= '0;
            prod3_q     <= '0;
            a3_q        <= '0;
            ia3_q       <= '0;
            ib3_q       <= '0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
            wr_data_a_q <= '0;
            wr_data_b_q <= '0;
        end else begin
            iss_q   <= (state_q == ISSUE);
            hi_q    <= pass_q;
            v1_q    <= iss_q;
            z1_q    <= zeta;
            ia1_q   <= idx_a;
            ib1_q   <= idx_b;
            v2_q    <= v1_q;
            prod_q  <= 24'(z1_q) * 24'(rd_data_b);
            a2_q    <= rd_data_a;
            ia2_q   <= ia1_q;
            ib2_q   <= ib1_q;
            v3_q    <= v2_q;
            quo_q   <= 12'((37'(prod_q) * 37'(M)) >> 24);
            prod3_q <= prod_q;
            a3_q    <= a2_q;
            ia3_q   <= ia2_q;
            ib3_q   <= ib2_q;
            wr_en_q <= v3_q;
            if (v3_q) begin
                wr_addr_a_q <= ia3_q;
                wr_addr_b_q <= ib3_q;
                wr_data_a_q <= a_new;
                wr_data_b_q <= b_new;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_addr  = rom_addr_q;
    assign rd_addr_a = iss_q ? idx_a : 8'd0;
    assign rd_addr_b = iss_q ? idx_b : 8'd0;
    assign wr_en     = wr_en_q;
    assign wr_addr_a = wr_addr_a_q;
    assign wr_addr_b = wr_addr_b_q;
    assign wr_data_a = wr_data_a_q;
    assign wr_data_b = wr_data_b_q;
endmodule

// File: doc/ntt_stage2_ctrl.md
# ntt_stage2_ctrl

Sequencer and butterfly datapath for the two NTT layers whose schedule is stored in the 128 x 64-bit layer-2 schedule ROM (`rom_gen_2`). It sits directly downstream of that ROM. It walks the ROM addresses, unpacks each word into butterfly descriptors, reads coefficient pairs from the external dual-port coefficient RAM, and runs Cooley-Tukey butterflies mod q = 3329. Results are written back in place.

## Interface
- `Q`, 3329: modulus; fixed, not for retargeting.
- `LAT`, 5: rom_addr-issue-to-write latency in cycles; documents the pipeline, not tunable.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted through the `done` cycle inclusive.
- `done`  out  1  one-cycle pulse after the final write.
- `rom_addr`  out  7  ROM address; registered.
- `rom_dout`  in  64  ROM data, valid one cycle after `rom_addr`.
- `rd_addr_a`, `rd_addr_b`  out  8 each  coefficient RAM read addresses.
- `rd_data_a`, `rd_data_b`  in  12 each  read data, valid one cycle after the address.
- `wr_en`  out  1  write strobe for both RAM ports.
- `wr_addr_a`, `wr_addr_b`  out  8 each  write addresses.
- `wr_data_a`, `wr_data_b`  out  12 each  write data, always < Q.

## Operation
- ROM word fields:
  - lo descriptor: `[27:16]` zeta_lo, `[15:8]` idx_a_lo, `[7:0]` idx_b_lo.
  - hi descriptor: `[59:48]` zeta_hi, `[47:40]` idx_a_hi, `[39:32]` idx_b_hi.
  - `[63:60]` and `[31:28]` are ignored.
- Two passes over addresses 0..127:
  - pass 0 uses the lo descriptors (len-32 layer);
  - pass 1 uses the hi descriptors (len-8 layer).
  - Each pass touches every index 0..255 exactly once, so there are no intra-pass hazards.
- The pipeline fully drains between passes. The first pass-1 read happens only after the last pass-0 write.
- Butterfly on a=coef[idx_a], b=coef[idx_b], zeta:
  - t = (zeta·b) mod Q, from a 24-bit exact product;
  - a' = (a+t) mod Q;
  - b' = (a−t) mod Q, with +Q on underflow.
  - Inputs are assumed < Q; reduction must be exact for all 12-bit zeta, b < Q.
- Zetas are used exactly as stored, with no Montgomery conversion.
- FSM states:
  - IDLE: `start` → ISSUE, pass=0, rom_addr=0.
  - ISSUE: rom_addr increments every cycle. After issuing address 127 → DRAIN.
  - DRAIN: waits until the last write of the pass completes. If pass=0, → ISSUE with pass=1 and rom_addr=0; if pass=1, → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` is ignored outside IDLE. A `start` held high after DONE starts a new run from IDLE.
- Reset, including mid-run: every output goes to 0 immediately and the FSM goes to IDLE. Partially written RAM contents are not restored.

## Timing
- Pipeline, for a rom_addr registered at cycle k:
  - k+1: rom_dout valid; rd_addr_a/b driven combinationally from the selected descriptor; zeta and indices registered.
  - k+2: rd_data valid; product registered.
  - k+3: reduction stage 1.
  - k+4: t registered.
  - k+5: `wr_en`=1 with registered addresses and data.
- One butterfly per cycle in ISSUE. `wr_en` is high for 128 consecutive cycles per pass.
- `start` sampled at cycle 0:
  - pass-0 rom_addr 0..127 at cycles 1..128; writes at 6..133;
  - pass-1 issue at 134..261; writes at 139..266;
  - `done` at cycle 267, `busy` falls at 268.
- Reset values: busy=0, done=0, wr_en=0, rom_addr=0, all address and data outputs 0.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release with no `start` → all outputs 0 and no `wr_en` for 20 cycles.
- All-zero RAM, real ROM contents, `start` at cycle 0:
  - exactly 256 writes, all data 0;
  - write address pairs in order: (0x00,0x20),(0x01,0x21)… then (0x00,0x08),(0x01,0x09)…;
  - `done` at cycle 267.
- coef[0]=1, coef[0x20]=1, others 0:
  - pass 0 writes coef[0]=1494, coef[0x20]=1837;
  - pass 1 pair (0,8) writes coef[0]=1494, coef[8]=1494.
- Wrap-around: coef[0]=coef[0x20]=3328, others 0 → pass 0 writes coef[0]=1835, coef[0x20]=1492.
- `start` pulsed again at cycles 10 and 200 → ignored; one `done`; 256 writes total.
- rst_n low at cycle 50 (mid pass 0):
  - busy, wr_en and rom_addr go to 0 within the same cycle;
  - a later `start` completes normally with `done` 267 cycles after it.
